// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, ALU_op encodings, FSM states and the control vector for the
// MIPS-subset CPU, shared by the Decoder and multicycle_ctrl.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [2:0] ALU_RFN   = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_SUBNE = 3'b011;
  localparam logic [2:0] ALU_SUBEQ = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_BRANCH, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_JUMP
  } state_t;
  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    return op == OP_ORI ? ALU_OR : op == OP_SLTI ? ALU_SLT : op == OP_LUI ? ALU_LUI : ALU_ADD;
  endfunction
endpackage

// File: rtl/ctrl_out_decode.sv
// ctrl_out_decode: maps FSM state (plus opcode and memory ready) to the datapath control vector.
module ctrl_out_decode
  import mips_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = 2'b01;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = 2'b11;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_RFN;
      end
      S_WB_R: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      S_EXEC_I: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b10;
        ctrl_o.alu_op    = imm_alu_op(op_i);
      end
      S_WB_I: ctrl_o.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = 2'b01;
        ctrl_o.branch_ne     = op_i == OP_BNE;
        ctrl_o.alu_op        = op_i == OP_BNE ? ALU_SUBNE : ALU_SUBEQ;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = 2'b10;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_req  = 1'b1;
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = 2'b10;
      end
      default: ctrl_o = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM sequencing the shared ALU/memory datapath,
// with retire/illegal pulses and a retired-instruction counter.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IorD_o,
  output logic             IRWrite_o,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic             BranchNE_o,
  output logic [1:0]       PCSource_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [2:0]       ALU_op_o,
  output logic             RegDst_o,
  output logic             MemtoReg_o,
  output logic             RegWrite_o,
  output logic             retire_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instr_cnt_o
);
  state_t           r_state, w_next;
  ctrl_t            w_ctrl, w_c;
  logic             r_retire, r_illegal, w_retire, w_illegal;
  logic [CNT_W-1:0] r_cnt;
  ctrl_out_decode u_dec (.state_i(r_state), .op_i(instr_op_i), .mem_ready_i(mem_ready_i), .ctrl_o(w_ctrl));
  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH: w_next = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        w_next = instr_op_i == OP_RTYPE ? S_EXEC_R
               : instr_op_i inside {OP_ADDI, OP_SLTI, OP_ORI, OP_LUI} ? S_EXEC_I
               : instr_op_i inside {OP_BEQ, OP_BNE} ? S_BRANCH
               : instr_op_i inside {OP_LW, OP_SW} ? S_MEM_ADDR
               : instr_op_i == OP_J ? S_JUMP : S_FETCH;
        w_illegal = w_next == S_FETCH;
      end
      S_EXEC_R:   w_next = S_WB_R;
      S_EXEC_I:   w_next = S_WB_I;
      S_MEM_ADDR: w_next = instr_op_i == OP_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = mem_ready_i ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR: begin
        w_next   = mem_ready_i ? S_FETCH : S_MEM_WR;
        w_retire = mem_ready_i;
      end
      S_WB_R, S_WB_I, S_BRANCH, S_MEM_WB, S_JUMP: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= S_FETCH;
      r_retire  <= 1'b0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_next;
      r_retire  <= w_retire;
      r_illegal <= w_illegal;
      r_cnt     <= r_cnt + CNT_W'(w_retire);
    end
  end
  // Reset is asynchronous in effect on the outputs: everything reads 0 while rst_i is low.
  assign w_c           = rst_i ? w_ctrl : '0;
  assign mem_req_o     = w_c.mem_req;
  assign MemRead_o     = w_c.mem_read;
  assign MemWrite_o    = w_c.mem_write;
  assign IorD_o        = w_c.iord;
  assign IRWrite_o     = w_c.ir_write;
  assign PCWrite_o     = w_c.pc_write;
  assign PCWriteCond_o = w_c.pc_write_cond;
  assign BranchNE_o    = w_c.branch_ne;
  assign PCSource_o    = w_c.pc_source;
  assign ALUSrcA_o     = w_c.alu_src_a;
  assign ALUSrcB_o     = w_c.alu_src_b;
  assign ALU_op_o      = w_c.alu_op;
  assign RegDst_o      = w_c.reg_dst;
  assign MemtoReg_o    = w_c.mem_to_reg;
  assign RegWrite_o    = w_c.reg_write;
  assign retire_o      = rst_i & r_retire;
  assign illegal_o     = rst_i & r_illegal;
  assign instr_cnt_o   = rst_i ? r_cnt : '0;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed sequence through reset, R/LW/BNE/BEQ/ORI/J, illegal opcode and reset during a store wait with scoreboarded retirements.
module tb_multicycle_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [5:0]  instr_op_i = 6'd0;
  logic        mem_ready_i = 1'b1;
  logic        mem_req_o, MemRead_o, MemWrite_o, IorD_o, IRWrite_o, PCWrite_o, PCWriteCond_o, BranchNE_o;
  logic [1:0]  PCSource_o, ALUSrcB_o;
  logic        ALUSrcA_o, RegDst_o, MemtoReg_o, RegWrite_o, retire_o, illegal_o;
  logic [2:0]  ALU_op_o;
  logic [31:0] instr_cnt_o;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  typedef struct {int cyc; logic [31:0] cnt;} exp_t;
  exp_t q[$];
  localparam logic [18:0] E_ZERO    = 19'b00000000_00_0_00_000_000;
  localparam logic [18:0] E_FETCH_W = 19'b11000000_00_0_01_001_000;
  localparam logic [18:0] E_FETCH_R = 19'b11001100_00_0_01_001_000;
  localparam logic [18:0] E_DECODE  = 19'b00000000_00_0_11_001_000;
  localparam logic [18:0] E_EXEC_R  = 19'b00000000_00_1_00_000_000;
  localparam logic [18:0] E_WB_R    = 19'b00000000_00_0_00_000_101;
  localparam logic [18:0] E_EXEC_OR = 19'b00000000_00_1_10_010_000;
  localparam logic [18:0] E_WB_I    = 19'b00000000_00_0_00_000_001;
  localparam logic [18:0] E_BR_NE   = 19'b00000011_01_1_00_011_000;
  localparam logic [18:0] E_BR_EQ   = 19'b00000010_01_1_00_100_000;
  localparam logic [18:0] E_MADDR   = 19'b00000000_00_1_10_001_000;
  localparam logic [18:0] E_MEM_RD  = 19'b11010000_00_0_00_000_000;
  localparam logic [18:0] E_MEM_WB  = 19'b00000000_00_0_00_000_011;
  localparam logic [18:0] E_MEM_WR  = 19'b10110000_00_0_00_000_000;
  localparam logic [18:0] E_JUMP    = 19'b00000100_10_0_00_000_000;
  logic [18:0] ctl;
  assign ctl = {mem_req_o, MemRead_o, MemWrite_o, IorD_o, IRWrite_o, PCWrite_o, PCWriteCond_o, BranchNE_o,
                PCSource_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o, RegDst_o, MemtoReg_o, RegWrite_o};
  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .mem_req_o(mem_req_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IorD_o(IorD_o),
    .IRWrite_o(IRWrite_o), .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .BranchNE_o(BranchNE_o),
    .PCSource_o(PCSource_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALU_op_o(ALU_op_o),
    .RegDst_o(RegDst_o), .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .retire_o(retire_o),
    .illegal_o(illegal_o), .instr_cnt_o(instr_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic sb();
    exp_t e;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("retire", retire_o, 1'b1);
      chk("retire_cnt", instr_cnt_o, e.cnt);
    end else chk("no_retire", retire_o, 1'b0);
  endtask
  task automatic step(input logic rst, input logic rdy, input logic [5:0] op);
    @(posedge clk_i);
    #1;
    rst_i = rst;
    mem_ready_i = rdy;
    instr_op_i = op;
    #3;
    sb();
  endtask
  task automatic push(input int lat, input logic [31:0] cnt);
    exp_t e;
    e.cyc = cyc + lat;
    e.cnt = cnt;
    q.push_back(e);
  endtask
  initial begin
    step(1'b0, 1'b1, 6'd0);
    step(1'b0, 1'b1, 6'd0);
    chk("rst_ctl", ctl, E_ZERO);
    chk("rst_pulses", {retire_o, illegal_o}, 2'b00);
    chk("rst_cnt", instr_cnt_o, 32'd0);
    step(1'b1, 1'b1, 6'd0);
    chk("r_fetch", ctl, E_FETCH_R);
    push(4, 32'd1);
    step(1'b1, 1'b1, 6'd0);
    chk("r_decode", ctl, E_DECODE);
    step(1'b1, 1'b1, 6'd0);
    chk("r_exec", ctl, E_EXEC_R);
    step(1'b1, 1'b1, 6'd0);
    chk("r_wb", ctl, E_WB_R);
    step(1'b1, 1'b1, 6'd35);
    chk("lw_fetch", ctl, E_FETCH_R);
    chk("cnt_after_r", instr_cnt_o, 32'd1);
    push(8, 32'd2);
    step(1'b1, 1'b1, 6'd35);
    step(1'b1, 1'b1, 6'd35);
    chk("lw_addr", ctl, E_MADDR);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 6'd35);
      chk("lw_rd_wait", ctl, E_MEM_RD);
    end
    step(1'b1, 1'b1, 6'd35);
    chk("lw_rd_ready", ctl, E_MEM_RD);
    step(1'b1, 1'b1, 6'd35);
    chk("lw_wb", ctl, E_MEM_WB);
    step(1'b1, 1'b1, 6'd5);
    push(3, 32'd3);
    step(1'b1, 1'b1, 6'd5);
    step(1'b1, 1'b1, 6'd5);
    chk("bne", ctl, E_BR_NE);
    step(1'b1, 1'b1, 6'd4);
    push(3, 32'd4);
    step(1'b1, 1'b1, 6'd4);
    step(1'b1, 1'b1, 6'd4);
    chk("beq", ctl, E_BR_EQ);
    step(1'b1, 1'b1, 6'd13);
    push(4, 32'd5);
    step(1'b1, 1'b1, 6'd13);
    step(1'b1, 1'b1, 6'd13);
    chk("ori_exec", ctl, E_EXEC_OR);
    step(1'b1, 1'b1, 6'd13);
    chk("ori_wb", ctl, E_WB_I);
    step(1'b1, 1'b1, 6'd2);
    push(3, 32'd6);
    step(1'b1, 1'b1, 6'd2);
    step(1'b1, 1'b1, 6'd2);
    chk("jump", ctl, E_JUMP);
    step(1'b1, 1'b1, 6'd6);
    step(1'b1, 1'b1, 6'd6);
    chk("ill_decode", ctl, E_DECODE);
    step(1'b1, 1'b0, 6'd6);
    chk("ill_pulse", illegal_o, 1'b1);
    chk("ill_back_fetch", ctl, E_FETCH_W);
    chk("ill_cnt", instr_cnt_o, 32'd6);
    step(1'b1, 1'b1, 6'd43);
    chk("ill_one_cycle", illegal_o, 1'b0);
    chk("sw_fetch", ctl, E_FETCH_R);
    step(1'b1, 1'b1, 6'd43);
    step(1'b1, 1'b1, 6'd43);
    chk("sw_addr", ctl, E_MADDR);
    step(1'b1, 1'b0, 6'd43);
    chk("sw_wait", ctl, E_MEM_WR);
    step(1'b0, 1'b0, 6'd43);
    chk("sw_rst_ctl", ctl, E_ZERO);
    step(1'b1, 1'b0, 6'd43);
    chk("post_rst_fetch", ctl, E_FETCH_W);
    chk("post_rst_cnt", instr_cnt_o, 32'd0);
    step(1'b1, 1'b0, 6'd43);
    step(1'b1, 1'b0, 6'd43);
    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
